// File: rtl/bp_nonsynth_mem_txn_tracker.sv
// Snoops a BedRock memory stream (mem_fwd requests, mem_rev responses) and checks in-order request/response pairing.
// Optional response timeout is compiled in with `define BP_MEM_TXN_TRACKER_TIMEOUT_EN.
module bp_nonsynth_mem_txn_tracker
  #(parameter int paddr_width_p = 40
    , parameter int did_width_p = 3
    , parameter int lce_id_width_p = 4
    , parameter int lce_assoc_p = 8
    , parameter int els_p = 8
    , parameter int timeout_p = 1024
    , parameter bit report_errors_p = 1'b1
    // Header layout, LSB first: msg_type[4], subop[4], addr[paddr], size[3], payload
    , localparam int mem_payload_width_lp = did_width_p + lce_id_width_p + $clog2(lce_assoc_p) + 3
    , localparam int mem_header_width_lp = mem_payload_width_lp + 3 + paddr_width_p + 4 + 4
    , localparam int cnt_width_lp = $clog2(els_p+1)
    )
    (input  logic                           clk_i
    , input  logic                           reset_n_i
    , input  logic [mem_header_width_lp-1:0] mem_fwd_header_i
    , input  logic                           mem_fwd_v_i
    , input  logic                           mem_fwd_ready_and_i
    , input  logic                           mem_fwd_last_i
    , input  logic [mem_header_width_lp-1:0] mem_rev_header_i
    , input  logic                           mem_rev_v_i
    , input  logic                           mem_rev_ready_and_i
    , input  logic                           mem_rev_last_i
    , output logic [cnt_width_lp-1:0]        outstanding_o
    , output logic [31:0]                    txn_count_o
    , output logic                           error_o
    , output logic [2:0]                     error_code_o
    );

    localparam int addr_lsb_lp    = 8;
    localparam int size_lsb_lp    = addr_lsb_lp + paddr_width_p;
    localparam int entry_width_lp = 4 + paddr_width_p + 3;
    localparam int ptr_width_lp   = $clog2(els_p);

    typedef enum logic {e_idle, e_burst} state_e;

    state_e fwd_state_r, fwd_state_n, rev_state_r, rev_state_n;
    logic   fwd_acc, rev_acc, fwd_hdr, rev_hdr;

    logic [entry_width_lp-1:0] fifo_mem [els_p];
    logic [entry_width_lp-1:0] fwd_entry, rev_entry, head_entry;
    logic [ptr_width_lp-1:0]   wr_ptr_r, rd_ptr_r;
    logic [cnt_width_lp-1:0]   count_r;
    logic [31:0]               txn_count_r;
    logic                      error_r;
    logic [2:0]                error_code_r, err_code_n;
    logic                      full, empty, do_push, do_pop;
    logic                      err_ovf, err_udf, err_mis, err_tmo, err_any, txn_inc;
    logic                      unused_hdr_bits;

    assign fwd_entry  = {mem_fwd_header_i[3:0], mem_fwd_header_i[addr_lsb_lp +: paddr_width_p],
                         mem_fwd_header_i[size_lsb_lp +: 3]};
    assign rev_entry  = {mem_rev_header_i[3:0], mem_rev_header_i[addr_lsb_lp +: paddr_width_p],
                         mem_rev_header_i[size_lsb_lp +: 3]};
    assign unused_hdr_bits = ^{mem_fwd_header_i[7:4], mem_fwd_header_i[mem_header_width_lp-1:size_lsb_lp+3],
                               mem_rev_header_i[7:4], mem_rev_header_i[mem_header_width_lp-1:size_lsb_lp+3]};

    assign fwd_acc = mem_fwd_v_i & mem_fwd_ready_and_i;
    assign rev_acc = mem_rev_v_i & mem_rev_ready_and_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fwd_state_r <= e_idle;
            rev_state_r <= e_idle;
        end else begin
            fwd_state_r <= fwd_state_n;
            rev_state_r <= rev_state_n;
        end
    end

    // Only the first accepted beat of a message carries a meaningful header
    always_comb begin
        fwd_state_n = fwd_state_r;
        rev_state_n = rev_state_r;
        fwd_hdr     = 1'b0;
        rev_hdr     = 1'b0;
        case (fwd_state_r)
            e_idle:  if (fwd_acc) begin
                         fwd_hdr = 1'b1;
                         if (!mem_fwd_last_i) fwd_state_n = e_burst;
                     end
            e_burst: if (fwd_acc && mem_fwd_last_i) fwd_state_n = e_idle;
            default: fwd_state_n = e_idle;
        endcase
        case (rev_state_r)
            e_idle:  if (rev_acc) begin
                         rev_hdr = 1'b1;
                         if (!mem_rev_last_i) rev_state_n = e_burst;
                     end
            e_burst: if (rev_acc && mem_rev_last_i) rev_state_n = e_idle;
            default: rev_state_n = e_idle;
        endcase
    end

    assign full       = (count_r == cnt_width_lp'(els_p));
    assign empty      = (count_r == '0);
    assign head_entry = fifo_mem[rd_ptr_r];
    assign do_pop     = rev_hdr & ~empty;
    // A pop in the same cycle frees the slot, so a push at full is still legal
    assign do_push    = fwd_hdr & (~full | do_pop);

    assign err_ovf = fwd_hdr & full & ~rev_hdr;
    assign err_udf = rev_hdr & empty;
    assign err_mis = do_pop & (head_entry != rev_entry);
    assign txn_inc = do_pop & (head_entry == rev_entry);

`ifdef BP_MEM_TXN_TRACKER_TIMEOUT_EN
    localparam int tmo_width_lp = $clog2(timeout_p+1);
    logic [tmo_width_lp-1:0] tmo_cnt_r;
    logic                    tmo_fired_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_cnt_r   <= '0;
            tmo_fired_r <= 1'b0;
        end else if (empty || rev_hdr) begin
            tmo_cnt_r   <= '0;
            tmo_fired_r <= 1'b0;
        end else begin
            if (tmo_cnt_r != tmo_width_lp'(timeout_p)) tmo_cnt_r <= tmo_cnt_r + tmo_width_lp'(1);
            if (err_tmo) tmo_fired_r <= 1'b1;
        end
    end

    // Counter parks at timeout_p; the fired flag keeps this a single event per stall
    assign err_tmo = (tmo_cnt_r == tmo_width_lp'(timeout_p)) & ~tmo_fired_r;
`else
    assign err_tmo = 1'b0;
`endif

    always_comb begin
        err_code_n = 3'd0;
        if (err_ovf)      err_code_n = 3'd1;
        else if (err_udf) err_code_n = 3'd2;
        else if (err_mis) err_code_n = 3'd3;
        else if (err_tmo) err_code_n = 3'd4;
    end
    assign err_any = (err_code_n != 3'd0);

    always_ff @(posedge clk_i) begin
        if (do_push) fifo_mem[wr_ptr_r] <= fwd_entry;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            txn_count_r  <= '0;
            error_r      <= 1'b0;
            error_code_r <= 3'd0;
        end else begin
            if (do_push) wr_ptr_r <= wr_ptr_r + ptr_width_lp'(1);
            if (do_pop)  rd_ptr_r <= rd_ptr_r + ptr_width_lp'(1);
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + cnt_width_lp'(1);
                2'b01:   count_r <= count_r - cnt_width_lp'(1);
                default: count_r <= count_r;
            endcase
            if (txn_inc && (txn_count_r != '1)) txn_count_r <= txn_count_r + 32'd1;
            if (err_any && !error_r) begin
                error_r      <= 1'b1;
                error_code_r <= err_code_n;
            end
        end
    end

    always @(posedge clk_i) begin
        if (report_errors_p && reset_n_i && err_any)
            $error("%m: mem txn error code %0d fwd{type=%h addr=%h size=%h} rev{type=%h addr=%h size=%h} head=%h time=%0t",
                   err_code_n, fwd_entry[entry_width_lp-1 -: 4], fwd_entry[3 +: paddr_width_p], fwd_entry[2:0],
                   rev_entry[entry_width_lp-1 -: 4], rev_entry[3 +: paddr_width_p], rev_entry[2:0],
                   head_entry, $time);
    end

    assign outstanding_o = count_r;
    assign txn_count_o   = txn_count_r;
    assign error_o       = error_r;
    assign error_code_o  = error_code_r;

endmodule

// File: tb/tb_bp_nonsynth_mem_txn_tracker.sv
// Directed bench for bp_nonsynth_mem_txn_tracker: vector table plus hand-written multi-cycle sequences.
module tb_bp_nonsynth_mem_txn_tracker;

    localparam int HDR_W = 64;
    localparam logic [3:0]  RD   = 4'h0;
    localparam logic [3:0]  WR   = 4'h1;
    localparam logic [2:0]  SZ64 = 3'b110;
    localparam logic [39:0] A0   = 40'h00_8000_0000;

    typedef struct packed {
        logic        v;
        logic        r;
        logic        l;
        logic [3:0]  t;
        logic [39:0] a;
        logic [2:0]  s;
    } beat_t;

    typedef struct {
        beat_t f;
        beat_t r;
        int    out;
        int    txn;
        logic  err;
        int    code;
    } vec_t;

    logic             clk;
    logic             reset_n;
    logic [HDR_W-1:0] fwd_header, rev_header;
    logic             fwd_v, fwd_ready, fwd_last, rev_v, rev_ready, rev_last;
    logic [3:0]       outstanding;
    logic [31:0]      txn_count;
    logic             error;
    logic [2:0]       error_code;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vt[$];

    bp_nonsynth_mem_txn_tracker #(.els_p(8), .timeout_p(16), .report_errors_p(1'b0)) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .mem_fwd_header_i    (fwd_header),
        .mem_fwd_v_i         (fwd_v),
        .mem_fwd_ready_and_i (fwd_ready),
        .mem_fwd_last_i      (fwd_last),
        .mem_rev_header_i    (rev_header),
        .mem_rev_v_i         (rev_v),
        .mem_rev_ready_and_i (rev_ready),
        .mem_rev_last_i      (rev_last),
        .outstanding_o       (outstanding),
        .txn_count_o         (txn_count),
        .error_o             (error),
        .error_code_o        (error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [HDR_W-1:0] mk(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s);
        return {13'h0a5, s, a, 4'h3, t};
    endfunction

    function automatic beat_t bt(input logic v, input logic r, input logic l,
                                 input logic [3:0] t, input logic [39:0] a, input logic [2:0] s);
        beat_t b;
        b.v = v; b.r = r; b.l = l; b.t = t; b.a = a; b.s = s;
        return b;
    endfunction

    function automatic beat_t s1(input logic [39:0] a);
        return bt(1'b1, 1'b1, 1'b1, RD, a, SZ64);
    endfunction

    function automatic beat_t nb();
        return bt(1'b0, 1'b0, 1'b0, 4'h0, 40'h0, 3'h0);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int out, input int txn, input logic err, input int code);
        check({tag, ".outstanding"}, 32'(outstanding), 32'(out));
        check({tag, ".txn_count"},   txn_count,        32'(txn));
        check({tag, ".error"},       32'(error),       32'(err));
        check({tag, ".error_code"},  32'(error_code),  32'(code));
    endtask

    // Drives one cycle of stimulus and returns just after the capturing edge
    task automatic apply(input beat_t f, input beat_t r);
        fwd_v = f.v; fwd_ready = f.r; fwd_last = f.l; fwd_header = mk(f.t, f.a, f.s);
        rev_v = r.v; rev_ready = r.r; rev_last = r.l; rev_header = mk(r.t, r.a, r.s);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply(nb(), nb());
        apply(nb(), nb());
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        fwd_v = 1'b0; fwd_ready = 1'b0; fwd_last = 1'b0; fwd_header = '0;
        rev_v = 1'b0; rev_ready = 1'b0; rev_last = 1'b0; rev_header = '0;

        vt.push_back(vec_t'{s1(A0),          nb(),          1, 0, 1'b0, 0});
        vt.push_back(vec_t'{s1(A0 + 'h40),   nb(),          2, 0, 1'b0, 0});
        vt.push_back(vec_t'{s1(A0 + 'h80),   nb(),          3, 0, 1'b0, 0});
        vt.push_back(vec_t'{nb(),            s1(A0),        2, 1, 1'b0, 0});
        vt.push_back(vec_t'{nb(),            s1(A0 + 'h40), 1, 2, 1'b0, 0});
        vt.push_back(vec_t'{nb(),            s1(A0 + 'h80), 0, 3, 1'b0, 0});
        vt.push_back(vec_t'{bt(1, 0, 1, RD, 40'h1000, SZ64), bt(1, 0, 1, RD, 40'h2000, SZ64), 0, 3, 1'b0, 0});
        vt.push_back(vec_t'{bt(1, 1, 0, RD, 40'h8000_1000, SZ64), nb(), 1, 3, 1'b0, 0});
        vt.push_back(vec_t'{bt(1, 1, 0, WR, 40'hdead, 3'b001),    nb(), 1, 3, 1'b0, 0});
        vt.push_back(vec_t'{bt(1, 1, 0, WR, 40'hbeef, 3'b010),    nb(), 1, 3, 1'b0, 0});
        vt.push_back(vec_t'{bt(1, 1, 1, RD, 40'h0, SZ64),         nb(), 1, 3, 1'b0, 0});
        vt.push_back(vec_t'{nb(), bt(1, 1, 0, RD, 40'h8000_1000, SZ64), 0, 4, 1'b0, 0});
        vt.push_back(vec_t'{nb(), bt(1, 1, 0, WR, 40'h1234, 3'b000),    0, 4, 1'b0, 0});
        vt.push_back(vec_t'{nb(), bt(1, 1, 0, WR, 40'h5678, 3'b011),    0, 4, 1'b0, 0});
        vt.push_back(vec_t'{nb(), bt(1, 1, 1, RD, 40'h9abc, SZ64),      0, 4, 1'b0, 0});
        vt.push_back(vec_t'{s1(A0 + 'h100),  nb(),            1, 4, 1'b0, 0});
        vt.push_back(vec_t'{s1(A0 + 'h140),  s1(A0 + 'h100),  1, 5, 1'b0, 0});
        vt.push_back(vec_t'{nb(),            s1(A0 + 'h140),  0, 6, 1'b0, 0});

        // Reset values
        #2;
        check_all("reset", 0, 0, 1'b0, 0);
        do_reset();

        foreach (vt[i]) begin
            apply(vt[i].f, vt[i].r);
            check_all($sformatf("vec%0d", i), vt[i].out, vt[i].txn, vt[i].err, vt[i].code);
        end

        // Overflow: ninth request alone
        do_reset();
        for (int i = 0; i < 8; i++) apply(s1(A0 + 40'(i * 64)), nb());
        check_all("fill8", 8, 0, 1'b0, 0);
        apply(s1(A0 + 'h1000), nb());
        check_all("overflow", 8, 0, 1'b1, 1);

        // Full queue with simultaneous response is legal
        do_reset();
        for (int i = 0; i < 8; i++) apply(s1(A0 + 40'(i * 64)), nb());
        apply(s1(A0 + 'h1000), s1(A0));
        check_all("full_swap", 8, 1, 1'b0, 0);
        apply(nb(), s1(A0 + 'h40));
        check_all("full_swap_next", 7, 2, 1'b0, 0);

        // Underflow with same-cycle request, then a sticky code over a later mismatch
        do_reset();
        apply(s1(A0 + 'h200), s1(A0 + 'h200));
        check_all("underflow", 1, 0, 1'b1, 2);
        apply(nb(), s1(A0 + 'h204));
        check_all("sticky", 0, 0, 1'b1, 2);

        // Mismatch on size alone
        do_reset();
        apply(s1(A0), nb());
        apply(nb(), bt(1, 1, 1, RD, A0, 3'b101));
        check_all("mismatch_size", 0, 0, 1'b1, 3);

        // Response timeout
        do_reset();
        apply(s1(A0), nb());
        check_all("tmo_push", 1, 0, 1'b0, 0);
        for (int i = 0; i < 16; i++) apply(nb(), nb());
        check_all("tmo_16", 1, 0, 1'b0, 0);
`ifdef BP_MEM_TXN_TRACKER_TIMEOUT_EN
        apply(nb(), nb());
        check_all("tmo_17", 1, 0, 1'b1, 4);
`else
        for (int i = 0; i < 84; i++) apply(nb(), nb());
        check_all("tmo_off_100", 1, 0, 1'b0, 0);
`endif

        // Asynchronous reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 4; i++) apply(s1(A0 + 40'(i * 64)), nb());
        apply(bt(1, 1, 0, RD, A0 + 'h300, SZ64), nb());
        check_all("burst_start", 5, 0, 1'b0, 0);
        apply(bt(1, 1, 0, RD, A0 + 'h400, SZ64), s1(A0));
        check_all("burst_mid", 4, 1, 1'b0, 0);
        fwd_v = 1'b1; fwd_ready = 1'b1; fwd_last = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 1'b0, 0);
        apply(nb(), nb());
        reset_n = 1'b1;
        apply(s1(A0 + 'h500), nb());
        check_all("post_reset_fwd", 1, 0, 1'b0, 0);
        apply(nb(), s1(A0 + 'h500));
        check_all("post_reset_rev", 0, 1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
